// File: rtl/spi_master.sv
// SPI mode-0 master: one full-duplex transfer per start, programmable divider, length and selects.
// Optional build macro SPI_MASTER_LSB_FIRST_EN adds the lsb_first input (LSB-first shifting).
//
// state | meaning
// IDLE  | waiting for start; ss_n released, mosi parked high
// SETUP | selects asserted, first bit on mosi, sck low for one half-period
// SHIFT | sck toggling; sample miso on rising sck, advance mosi on falling sck
// HOLD  | sck low for one half-period before releasing selects and pulsing done
module spi_master #(
    parameter int DATA_W = 32,
    parameter int DIV_W  = 16,
    parameter int SS_W   = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic [$clog2(DATA_W):0]   char_len,
    input  logic [DIV_W-1:0]          div,
    input  logic [SS_W-1:0]           ss_sel,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      sck,
    output logic [SS_W-1:0]           ss_n,
    output logic                      mosi,
    input  logic                      miso
`ifdef SPI_MASTER_LSB_FIRST_EN
    ,
    input  logic                      lsb_first
`endif
);
    localparam int LEN_W = $clog2(DATA_W) + 1;
    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [LEN_W-1:0]    bits_q, bits_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic [SS_W-1:0]     ss_n_q, ss_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [LEN_W-1:0]    len_in;
    logic [LEN_W-1:0]    len_m1;
    logic [IDX_W-1:0]    idx_first;
    logic [IDX_W-1:0]    idx_nx;
    logic                sample;
    logic                lsb_in;
    logic                lsb_mode;

`ifdef SPI_MASTER_LSB_FIRST_EN
    logic lsb_q, lsb_d;
    assign lsb_in   = lsb_first;
    assign lsb_mode = lsb_q;
`else
    assign lsb_in   = 1'b0;
    assign lsb_mode = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bits_d    = bits_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        ss_n_d    = ss_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sample    = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_d     = lsb_q;
`endif
        len_in    = (char_len == '0) ? LEN_W'(DATA_W) : char_len;
        len_m1    = len_in - LEN_W'(1);
        idx_first = lsb_in ? '0 : len_m1[IDX_W-1:0];
        idx_nx    = lsb_mode ? (idx_q + IDX_W'(1)) : (idx_q - IDX_W'(1));

        case (state_q)
            IDLE: begin
                // the done cycle itself never accepts, so back-to-back starts are spaced by one cycle
                if (start && !done_q) begin
                    state_d = SETUP;
                    cnt_d   = div;
                    div_d   = div;
                    bits_d  = len_in;
                    idx_d   = idx_first;
                    tx_d    = tx_data;
                    rx_sh_d = '0;
                    mosi_d  = tx_data[idx_first];
                    ss_n_d  = ~ss_sel;
                    busy_d  = 1'b1;
`ifdef SPI_MASTER_LSB_FIRST_EN
                    lsb_d   = lsb_first;
`endif
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = div_q;
                    state_d = SHIFT;
                    sck_d   = 1'b1;
                    sample  = 1'b1;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q;
                    if (sck_q) begin
                        sck_d  = 1'b0;
                        bits_d = bits_q - LEN_W'(1);
                        if (bits_q != LEN_W'(1)) begin
                            idx_d  = idx_nx;
                            mosi_d = tx_q[idx_nx];
                        end
                    end else if (bits_q == '0) begin
                        // last low half-period finished
                        state_d = HOLD;
                    end else begin
                        sck_d  = 1'b1;
                        sample = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    ss_n_d    = '1;
                    mosi_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (sample) begin
            if (lsb_mode) begin
                rx_sh_d[idx_q] = miso;
            end else begin
                rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bits_q    <= '0;
            idx_q     <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b1;
            ss_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bits_q    <= bits_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            ss_n_q    <= ss_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb_q     <= lsb_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sck     = sck_q;
    assign ss_n    = ss_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: scoreboard of expected rx words popped on each done pulse.
module tb_spi_master;
    localparam int DATA_W = 32;
    localparam int DIV_W  = 16;
    localparam int SS_W   = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [DATA_W-1:0]  tx_data = '0;
    logic [5:0]         char_len = '0;
    logic [DIV_W-1:0]   div = '0;
    logic [SS_W-1:0]    ss_sel = '0;
    logic               busy, done, sck, mosi, miso;
    logic [DATA_W-1:0]  rx_data;
    logic [SS_W-1:0]    ss_n;
    logic               loop_en = 1'b1;
    logic               miso_fix = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic               lsb_first = 1'b0;
`endif

    assign miso = loop_en ? mosi : miso_fix;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] sb_exp;
    logic [SS_W-1:0]   exp_ss = '1;

    int                cap_cycles, cap_pulses, cap_ss_bad, cap_mosi_hi;
    int                cap_hi_min, cap_hi_max, cap_lo_min, cap_lo_max;
    logic [DATA_W-1:0] cap_bits;
    logic              cap_busy1, cap_done;

    spi_master #(.DATA_W(DATA_W), .DIV_W(DIV_W), .SS_W(SS_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .tx_data  (tx_data),
        .char_len (char_len),
        .div      (div),
        .ss_sel   (ss_sel),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .sck      (sck),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso)
`ifdef SPI_MASTER_LSB_FIRST_EN
        ,
        .lsb_first(lsb_first)
`endif
    );

    always #5 clock = ~clock;

    // scoreboard: every done pulse must match the oldest pending expected word
    always @(posedge clock) begin
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done rx_data=%h with no transfer pending", rx_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (rx_data !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_rx_data got %h expected %h", rx_data, sb_exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_xfer(input logic [31:0] tx, input logic [5:0] len,
                              input logic [15:0] dv, input logic [7:0] ss);
        tx_data  = tx;
        char_len = len;
        div      = dv;
        ss_sel   = ss;
        exp_ss   = ~ss;
        start    = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        // scramble configuration: must not affect the running transfer
        tx_data  = ~tx;
        char_len = len + 6'd3;
        div      = dv + 16'd5;
        ss_sel   = ~ss;
    endtask

    task automatic wait_done(input int max_cyc);
        logic prev;
        int   run;
        prev = 1'b0; run = 0;
        cap_cycles = 0; cap_pulses = 0; cap_bits = '0; cap_ss_bad = 0; cap_mosi_hi = 0;
        cap_hi_min = 100000; cap_hi_max = 0; cap_lo_min = 100000; cap_lo_max = 0;
        cap_busy1 = 1'b0; cap_done = 1'b0;
        while (cap_cycles < max_cyc && !cap_done) begin
            @(posedge clock); #1;
            cap_cycles++;
            if (cap_cycles == 1) cap_busy1 = busy;
            if (done === 1'b1) begin
                cap_done = 1'b1;
            end else begin
                if (busy === 1'b1 && ss_n !== exp_ss) cap_ss_bad++;
                if (busy === 1'b1 && mosi !== 1'b0) cap_mosi_hi++;
            end
            if (sck !== prev) begin
                if (prev) begin
                    if (run < cap_hi_min) cap_hi_min = run;
                    if (run > cap_hi_max) cap_hi_max = run;
                end else if (cap_pulses > 0) begin
                    if (run < cap_lo_min) cap_lo_min = run;
                    if (run > cap_lo_max) cap_lo_max = run;
                end
                if (sck) begin
                    cap_pulses++;
                    cap_bits = {cap_bits[DATA_W-2:0], mosi};
                end
                run = 1;
            end else begin
                run++;
            end
            prev = sck;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++; if (sck !== 1'b0)    begin errors++; $display("FAIL reset_sck got %b expected 0", sck); end
        checks++; if (ss_n !== 8'hFF)  begin errors++; $display("FAIL reset_ss_n got %h expected ff", ss_n); end
        checks++; if (mosi !== 1'b1)   begin errors++; $display("FAIL reset_mosi got %b expected 1", mosi); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (rx_data !== '0)  begin errors++; $display("FAIL reset_rx_data got %h expected 0", rx_data); end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_loopback_a5();
        loop_en = 1'b1;
        exp_q.push_back(32'h0000_00A5);
        start_xfer(32'h0000_00A5, 6'd8, 16'd0, 8'h01);
        wait_done(100);
        checks++; if (cap_cycles != 18) begin errors++; $display("FAIL a5_latency got %0d cycles expected 18", cap_cycles); end
        checks++; if (cap_busy1 !== 1'b1) begin errors++; $display("FAIL a5_busy_t1 got %b expected 1", cap_busy1); end
        checks++; if (cap_pulses != 8) begin errors++; $display("FAIL a5_sck_pulses got %0d expected 8", cap_pulses); end
        checks++; if (cap_bits[7:0] !== 8'hA5) begin errors++; $display("FAIL a5_mosi_seq got %b expected 10100101", cap_bits[7:0]); end
        checks++; if (cap_ss_bad != 0) begin errors++; $display("FAIL a5_ss_n got %0d bad cycles expected 0 (ss_n should be fe)", cap_ss_bad); end
        checks++; if (cap_hi_min != 1 || cap_hi_max != 1) begin errors++; $display("FAIL a5_sck_high got %0d..%0d expected 1", cap_hi_min, cap_hi_max); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (rx_data !== 32'h0000_00A5) begin errors++; $display("FAIL a5_rx_hold got %h expected 000000a5", rx_data); end
        checks++; if (ss_n !== 8'hFF || mosi !== 1'b1) begin errors++; $display("FAIL a5_idle_lines got ss_n=%h mosi=%b expected ff/1", ss_n, mosi); end
    endtask

    task automatic test_loopback_32();
        loop_en = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        start_xfer(32'hDEAD_BEEF, 6'd0, 16'd3, 8'h80);
        wait_done(400);
        checks++; if (cap_cycles != 264) begin errors++; $display("FAIL w32_latency got %0d cycles expected 264", cap_cycles); end
        checks++; if (cap_pulses != 32) begin errors++; $display("FAIL w32_sck_pulses got %0d expected 32", cap_pulses); end
        checks++; if (cap_bits !== 32'hDEAD_BEEF) begin errors++; $display("FAIL w32_mosi_seq got %h expected deadbeef", cap_bits); end
        checks++; if (cap_hi_min != 4 || cap_hi_max != 4) begin errors++; $display("FAIL w32_sck_high got %0d..%0d expected 4", cap_hi_min, cap_hi_max); end
        checks++; if (cap_lo_min != 4 || cap_lo_max != 4) begin errors++; $display("FAIL w32_sck_low got %0d..%0d expected 4", cap_lo_min, cap_lo_max); end
        checks++; if (cap_ss_bad != 0) begin errors++; $display("FAIL w32_ss_n got %0d bad cycles expected 0 (ss_n should be 7f)", cap_ss_bad); end
        @(posedge clock); #1;
    endtask

    task automatic test_miso_high();
        loop_en  = 1'b0;
        miso_fix = 1'b1;
        exp_q.push_back(32'h0000_001F);
        start_xfer(32'h0000_0000, 6'd5, 16'd1, 8'h00);
        wait_done(100);
        checks++; if (cap_cycles != 24) begin errors++; $display("FAIL m1_latency got %0d cycles expected 24", cap_cycles); end
        checks++; if (cap_pulses != 5) begin errors++; $display("FAIL m1_sck_pulses got %0d expected 5", cap_pulses); end
        checks++; if (cap_mosi_hi != 0) begin errors++; $display("FAIL m1_mosi_low got %0d high cycles expected 0", cap_mosi_hi); end
        checks++; if (cap_ss_bad != 0) begin errors++; $display("FAIL m1_ss_n got %0d bad cycles expected 0 (ss_n should be ff)", cap_ss_bad); end
        loop_en  = 1'b1;
        miso_fix = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int base;
        loop_en = 1'b1;
        base = done_cnt;
        exp_q.push_back(32'h0000_003C);
        start_xfer(32'h0000_003C, 6'd8, 16'd0, 8'h02);
        @(posedge clock); #1;
        tx_data = 32'h0000_00C3;
        start   = 1'b1;
        @(posedge clock); #1;
        start   = 1'b0;
        wait_done(100);
        checks++; if (!cap_done) begin errors++; $display("FAIL b2b_first_done got timeout expected done"); end
        // start during the done cycle must be ignored
        start   = 1'b1;
        tx_data = 32'h0000_0099;
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_cycle_start got busy=%b expected 0", busy); end
        tx_data = 32'h0000_005A;
        char_len = 6'd8;
        div     = 16'd0;
        ss_sel  = 8'h02;
        exp_q.push_back(32'h0000_005A);
        @(posedge clock); #1;
        start   = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_after_done got busy=%b expected 1", busy); end
        wait_done(100);
        checks++; if (cap_cycles != 18) begin errors++; $display("FAIL b2b_second_latency got %0d cycles expected 18", cap_cycles); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (done_cnt != base + 2) begin errors++; $display("FAIL b2b_done_count got %0d expected %0d", done_cnt - base, 2); end
    endtask

    task automatic test_reset_mid();
        int base;
        int n;
        loop_en = 1'b1;
        base = done_cnt;
        start_xfer(32'h0000_0000, 6'd8, 16'd0, 8'h01);
        n = 0;
        while (sck !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        checks++; if (sck !== 1'b1) begin errors++; $display("FAIL rmid_reach_shift got sck=%b expected 1", sck); end
        reset = 1'b1;
        #1;
        checks++; if (sck !== 1'b0)   begin errors++; $display("FAIL rmid_sck got %b expected 0", sck); end
        checks++; if (ss_n !== 8'hFF) begin errors++; $display("FAIL rmid_ss_n got %h expected ff", ss_n); end
        checks++; if (mosi !== 1'b1)  begin errors++; $display("FAIL rmid_mosi got %b expected 1", mosi); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rmid_busy got %b expected 0", busy); end
        checks++; if (rx_data !== '0) begin errors++; $display("FAIL rmid_rx_data got %h expected 0", rx_data); end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        checks++; if (done_cnt != base) begin errors++; $display("FAIL rmid_no_done got %0d done pulses expected 0", done_cnt - base); end
    endtask

`ifdef SPI_MASTER_LSB_FIRST_EN
    task automatic test_lsb_first();
        loop_en   = 1'b1;
        lsb_first = 1'b1;
        exp_q.push_back(32'h0000_0001);
        start_xfer(32'h0000_0001, 6'd8, 16'd0, 8'h01);
        lsb_first = 1'b0;
        wait_done(100);
        checks++; if (cap_bits[7:0] !== 8'b1000_0000) begin errors++; $display("FAIL lsb_mosi_seq got %b expected 10000000", cap_bits[7:0]); end
        checks++; if (cap_cycles != 18) begin errors++; $display("FAIL lsb_latency got %0d cycles expected 18", cap_cycles); end
        @(posedge clock); #1;
        lsb_first = 1'b1;
        exp_q.push_back(32'h0000_0034);
        start_xfer(32'h0000_0034, 6'd6, 16'd1, 8'h01);
        lsb_first = 1'b0;
        wait_done(100);
        checks++; if (cap_bits[5:0] !== 6'b001011) begin errors++; $display("FAIL lsb6_mosi_seq got %b expected 001011", cap_bits[5:0]); end
        @(posedge clock); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_loopback_a5();
        test_loopback_32();
        test_miso_high();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_MASTER_LSB_FIRST_EN
        test_lsb_first();
`endif
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_pending got %0d outstanding words expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
